// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline hazard definitions: FSM encodings, watchdog limit, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Register-file address width of the pipeline.
  localparam int REG_ADDR_W = 5;

  // Memory-wait watchdog: counter width and the count at which the wait is abandoned.
  localparam int                  WAIT_CNT_W = 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = 8'd255;

  // Width of the optional performance counters.
  localparam int PERF_CNT_W = 32;

  // Hazard FSM encodings; code 3 is unused and recovers to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } hz_state_e;

  // Bundle of pipeline control strobes produced each cycle.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_clr;
    logic idex_clr;
  } hz_ctrl_t;

  // True when a used source register names the given destination register.
  function automatic logic src_hit(input logic                  i_src_used,
                                   input logic [REG_ADDR_W-1:0] i_src,
                                   input logic [REG_ADDR_W-1:0] i_dst);
    return i_src_used & (i_src == i_dst);
  endfunction

endpackage

// File: rtl/hazard_ldu_detect.sv
// Load-use detector: flags an ID instruction that reads the destination of a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; result is consumed by hazard_ctrl.
module hazard_ldu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  output logic                  o_load_use
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rs1_hit    = src_hit(i_id_use_rs1, i_id_rs1, i_ex_rd);
  assign w_rs2_hit    = src_hit(i_id_use_rs2, i_id_rs2, i_ex_rd);

  assign o_load_use = i_ex_mem_read & w_rd_nonzero & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with watchdog, redirect flush, load-use bubble.
// Latency: control outputs combinational from inputs and current state; state/watchdog update on posedge clk.
// Backpressure: mem_req without mem_ack freezes the whole pipeline until ack, drop of req, or watchdog expiry.
// Optional build macro HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  ifid_clr,
  output logic                  idex_clr,
  output logic                  mem_timeout,
  output logic [1:0]            state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count
`endif
);

  hz_state_e             r_state;
  hz_state_e             w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                  r_mem_timeout;
  logic                  w_timeout_set;

  logic                  w_mem_hold;
  logic                  w_load_use;
  logic                  w_redirect_taken;
  hz_ctrl_t              w_ctrl;

  // Once the watchdog has fired, an outstanding request no longer holds the pipeline.
  assign w_mem_hold = mem_req & ~mem_ack & (r_state != ST_TIMEOUT);

  hazard_ldu_detect u_ldu (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .o_load_use    (w_load_use)
  );

  // Control strobes: reset flushes, then memory hold > redirect > load-use bubble.
  always_comb begin
    w_ctrl           = '0;
    w_redirect_taken = 1'b0;
    if (!rst_n) begin
      w_ctrl.ifid_clr = 1'b1;
      w_ctrl.idex_clr = 1'b1;
    end else if (w_mem_hold) begin
      w_ctrl.pc_stall    = 1'b1;
      w_ctrl.ifid_stall  = 1'b1;
      w_ctrl.idex_stall  = 1'b1;
      w_ctrl.exmem_stall = 1'b1;
    end else if (ex_redirect) begin
      w_ctrl.ifid_clr  = 1'b1;
      w_ctrl.idex_clr  = 1'b1;
      w_redirect_taken = 1'b1;
    end else if (w_load_use) begin
      w_ctrl.pc_stall   = 1'b1;
      w_ctrl.ifid_stall = 1'b1;
      w_ctrl.idex_clr   = 1'b1;
    end
  end

  // Next state and watchdog counter; the counter only runs while waiting on memory.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_timeout_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_hold) begin
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack || !mem_req) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == WAIT_LIMIT) begin
          w_state_nxt   = ST_TIMEOUT;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_TIMEOUT: begin
        if (!mem_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, watchdog counter and sticky timeout flag; reset abandons any wait at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
    end
  end

  assign pc_stall    = w_ctrl.pc_stall;
  assign ifid_stall  = w_ctrl.ifid_stall;
  assign idex_stall  = w_ctrl.idex_stall;
  assign exmem_stall = w_ctrl.exmem_stall;
  assign ifid_clr    = w_ctrl.ifid_clr;
  assign idex_clr    = w_ctrl.idex_clr;
  assign mem_timeout = r_mem_timeout;
  assign state       = r_state;

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cycles;
  logic [PERF_CNT_W-1:0] r_flush_count;

  // Saturating counters of stalled cycles and honoured redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_ctrl.pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_redirect_taken && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  // Redirect tracking is only consumed by the performance counters.
  logic w_unused_redirect;
  assign w_unused_redirect = w_redirect_taken;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls, a negedge monitor checks them.
// Latency: expectations apply to the same cycle the inputs are driven.
// Backpressure: n/a.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_mem_read, ex_redirect, mem_req, mem_ack;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_clr, idex_clr, mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .idex_stall  (idex_stall),
    .exmem_stall (exmem_stall),
    .ifid_clr    (ifid_clr),
    .idex_clr    (idex_clr),
    .mem_timeout (mem_timeout),
    .state       (state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  // Control vector order: {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_CLR   = 6'b000011;
  localparam logic [5:0] C_MEM   = 6'b111100;
  localparam logic [5:0] C_LDU   = 6'b110001;

  typedef struct {
    string      nm;
    logic [5:0] ctrl;
    logic [1:0] st;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [5:0] ec;
  logic [1:0] es;
  logic       eto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after posedge and queue the expected response.
  task automatic step(input string nm, input logic rn,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic redir,
                      input logic req, input logic ack,
                      input logic [5:0] xc, input logic [1:0] xs, input logic xt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rn;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    ex_rd       = rd;
    ex_mem_read = mr;
    ex_redirect = redir;
    mem_req     = req;
    mem_ack     = ack;
    e.nm   = nm;
    e.ctrl = xc;
    e.st   = xs;
    e.to   = xt;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are valid mid-cycle; pop and compare one expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = sb_q.pop_front();
      act = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr};
      total++;
      if (act !== e.ctrl || state !== e.st || mem_timeout !== e.to) begin
        bad++;
        $display("FAIL %s: got ctrl=%b state=%0d timeout=%b, want ctrl=%b state=%0d timeout=%b",
                 e.nm, act, state, mem_timeout, e.ctrl, e.st, e.to);
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

    //    name         rn rs1 u1 rs2 u2 rd mr rd  req ack  ctrl    st to
    step("reset0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_CLR,  0, 0);
    step("reset1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_CLR,  0, 0);
    step("idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    // Load-use bubbles and their non-matching variants.
    step("ldu_rs1",    1, 5, 1, 0, 0, 5, 1, 0, 0, 0, C_LDU,  0, 0);
    step("ldu_gone",   1, 5, 1, 0, 0, 6, 0, 0, 0, 0, C_NONE, 0, 0);
    step("ldu_rs2",    1, 3, 1, 7, 1, 7, 1, 0, 0, 0, C_LDU,  0, 0);
    step("ldu_unused", 1, 5, 0, 2, 1, 5, 1, 0, 0, 0, C_NONE, 0, 0);
    step("ldu_noload", 1, 5, 1, 0, 0, 5, 0, 0, 0, 0, C_NONE, 0, 0);
    step("ldu_x0",     1, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_NONE, 0, 0);

    // Redirect flush, alone and over a load-use.
    step("redir",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_CLR,  0, 0);
    step("redir_ldu",  1, 5, 1, 0, 0, 5, 1, 1, 0, 0, C_CLR,  0, 0);

    // Memory wait with ack on the fourth cycle.
    step("mw_a",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  0, 0);
    step("mw_b",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 0);
    step("mw_c",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 0);
    step("mw_ack",     1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 1, 0);
    step("mw_done",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    // Ack, redirect and load-use together: redirect wins.
    step("sim_a",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  0, 0);
    step("sim_b",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 0);
    step("sim_c",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 0);
    step("sim_all",    1, 5, 1, 0, 0, 5, 1, 1, 1, 1, C_CLR,  1, 0);
    step("sim_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    // Memory hold outranks redirect; dropping req ends the wait.
    step("hold_redir", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,  0, 0);
    step("req_drop",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0);
    step("req_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    // Watchdog: 1 RUN cycle + 256 MEM_WAIT cycles stalled, then TIMEOUT releases.
    for (int i = 0; i < 260; i++) begin
      es  = (i == 0) ? 2'd0 : ((i <= 256) ? 2'd1 : 2'd2);
      eto = (i >= 257);
      if (i <= 256)      ec = C_MEM;
      else if (i == 258) ec = C_CLR;
      else if (i == 259) ec = C_LDU;
      else               ec = C_NONE;
      if (i == 259) step("wd_ldu", 1, 9, 1, 0, 0, 9, 1, 0, 1, 0, ec, es, eto);
      else          step("wd", 1, 0, 0, 0, 0, 0, 0, (i == 258), 1, 0, ec, es, eto);
    end
    step("to_reqdrop", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2, 1);
    step("to_run",     1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 1);
    step("to_sticky",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 1);

    // Reset asserted mid-wait takes effect before the next clock edge.
    step("rw_a",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  0, 1);
    step("rw_b",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,  1, 1);
    step("rw_rst",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_CLR,  0, 0);
    step("rw_rst2",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_CLR,  0, 0);
    step("rw_release", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the ID instruction reads that source.
REQ-005 SHALL have port ex_rd, input, 5 bits: destination register of the EX instruction.
REQ-006 SHALL have port ex_mem_read, input, 1 bit: the EX instruction is a load.
REQ-007 SHALL have port ex_redirect, input, 1 bit: branch taken or jump resolved in EX.
REQ-008 SHALL have ports mem_req and mem_ack, input, 1 bit each: data-memory request from MEM and completion from memory.
REQ-009 SHALL have ports pc_stall, ifid_stall, idex_stall and exmem_stall, output, 1 bit each: hold the PC or that pipeline register.
REQ-010 SHALL have ports ifid_clr and idex_clr, output, 1 bit each: flush that pipeline register.
REQ-011 SHALL have port mem_timeout, output, 1 bit: sticky watchdog flag.
REQ-012 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1 and TIMEOUT=2; code 3 is illegal and SHALL recover to RUN on the next clock.
REQ-014 SHALL set mem_hold = mem_req & ~mem_ack & (state != TIMEOUT).
REQ-015 SHALL, while mem_hold=1, assert pc_stall, ifid_stall, idex_stall and exmem_stall together, with both clr outputs at 0.
REQ-016 SHALL, when mem_hold=0 and ex_redirect=1, assert ifid_clr and idex_clr in that same cycle, with all stalls at 0.
REQ-017 SHALL define load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 SHALL, when mem_hold=0, ex_redirect=0 and load_use=1, assert pc_stall, ifid_stall and idex_clr for exactly that cycle.
REQ-019 SHALL apply priority mem_hold > ex_redirect > load_use; all control outputs are combinational from inputs and the current state.
REQ-020 SHALL move RUN->MEM_WAIT when mem_hold=1.
REQ-021 SHALL move MEM_WAIT->RUN on the first cycle in which mem_ack=1 or mem_req=0.
REQ-022 SHALL keep an 8-bit wait counter that is zeroed in RUN and increments each cycle in MEM_WAIT.
REQ-023 SHALL, when the wait counter equals 255 and mem_ack=0, move to TIMEOUT and set mem_timeout=1.
REQ-024 SHALL in TIMEOUT release all stalls, behave as RUN for redirect and load-use, and return to RUN when mem_req=0.
REQ-025 SHALL hold mem_timeout set until reset.
REQ-026 SHALL, when mem_ack arrives in the same cycle as ex_redirect, honour the redirect in that cycle.

Reset
REQ-027 SHALL, while rst_n=0, force state=RUN, wait counter=0 and mem_timeout=0.
REQ-028 SHALL, while rst_n=0, drive all stalls to 0 and ifid_clr=idex_clr=1.
REQ-029 SHALL, when rst_n is asserted in MEM_WAIT, abandon the wait immediately.
REQ-030 SHALL treat deassertion of rst_n as synchronous to clk externally.

Configuration
REQ-031 SHALL, when HAZARD_PERF_EN is defined, add 32-bit outputs stall_cycles and flush_count.
REQ-032 SHALL, under HAZARD_PERF_EN, increment stall_cycles on every cycle with pc_stall=1 and flush_count on every cycle with ex_redirect honoured; both saturate at 0xFFFFFFFF and reset to 0.
REQ-033 SHALL, without HAZARD_PERF_EN, omit these ports and counters entirely.

Structure
REQ-034 SHALL place the state encodings, the watchdog limit (255) and the counter width in the shared pipeline package.
REQ-035 SHALL implement the load-use comparator as sub-module hazard_ldu_detect; the rest is flat.

Verification
REQ-036 SHALL test load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle of pc_stall=ifid_stall=idex_clr=1.
REQ-037 SHALL test the x0 case: same as REQ-036 with ex_rd=0 -> no stall and no clr.
REQ-038 SHALL test memory wait: mem_req=1 with mem_ack delayed 3 cycles -> all four stalls high 3 cycles, state=1, then state=0.
REQ-039 SHALL test simultaneous events: mem_ack=1, ex_redirect=1 and load_use=1 in one cycle -> ifid_clr=idex_clr=1 and pc_stall=0.
REQ-040 SHALL test the watchdog: mem_req=1 and mem_ack=0 for 260 cycles -> TIMEOUT after 256 wait cycles, stalls drop, mem_timeout stays 1.
REQ-041 SHALL test reset mid-wait: rst_n low in MEM_WAIT -> state=0, stalls=0, clr=1 immediately, without waiting for clk.
